// File: rtl/mem_access.sv
// mem_access: pipeline memory stage with req/ack data port and MEM/WB register.
// Holds the pipeline while a load or store waits for the memory acknowledge.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              cregwa_i,
    input  logic [1:0]        cregwd_i,
    input  logic              regwe_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [31:0]       aluout_i,
    input  logic              memre_i,
    input  logic              memwe_i,
    input  logic [1:0]        memsz_i,
    input  logic              memsx_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [3:0]        dm_be_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [31:0]       dm_rdata_i,
    output logic              valid_o,
    output logic              cregwa_o,
    output logic [1:0]        cregwd_o,
    output logic              regwe_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [31:0]       aluout_o,
    output logic [31:0]       memrd_o,
    output logic              misalign_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state_q, state_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        sz_q, sz_d;
    logic              sx_q, sx_d;
    logic [1:0]        lane_q, lane_d;

    logic              valid_q, valid_d;
    logic              cregwa_q, cregwa_d;
    logic [1:0]        cregwd_q, cregwd_d;
    logic              regwe_q, regwe_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       aluout_q, aluout_d;
    logic [31:0]       memrd_q, memrd_d;
    logic              mis_q, mis_d;

    logic [1:0]  lane;
    logic        is_mem, is_byte, is_half, is_word, misal;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;

    assign lane    = aluout_i[1:0];
    assign is_mem  = memre_i | memwe_i;
    assign is_byte = (memsz_i == 2'b00);
    assign is_half = (memsz_i == 2'b01);
    assign is_word = memsz_i[1];
    assign misal   = (is_half & lane[0]) | (is_word & (lane != 2'b00));

    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata_i;
        if (is_byte) begin
            st_be   = 4'b0001 << lane;
            st_data = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            st_be   = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_i[15:0]}};
        end
    end

    // Load extraction uses the latched size/lane, not the live inputs
    assign ld_b = dm_rdata_i[{lane_q, 3'b000} +: 8];
    assign ld_h = lane_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];

    always_comb begin
        ld_data = dm_rdata_i;
        if (sz_q == 2'b00)
            ld_data = {{24{sx_q & ld_b[7]}}, ld_b};
        else if (sz_q == 2'b01)
            ld_data = {{16{sx_q & ld_h[15]}}, ld_h};
    end

    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        req_d    = req_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sz_d     = sz_q;
        sx_d     = sx_q;
        lane_d   = lane_q;
        valid_d  = 1'b0;
        regwe_d  = 1'b0;
        mis_d    = 1'b0;
        cregwa_d = cregwa_q;
        cregwd_d = cregwd_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        aluout_d = aluout_q;
        memrd_d  = memrd_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i && is_mem && !misal) begin
                    stall_o = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = memwe_i;
                    be_d    = memwe_i ? st_be : 4'b0000;
                    addr_d  = {aluout_i[ADDR_W-1:2], 2'b00};
                    wdata_d = memwe_i ? st_data : 32'h0;
                    sz_d    = memsz_i;
                    sx_d    = memsx_i;
                    lane_d  = lane;
                end else begin
                    valid_d  = valid_i;
                    regwe_d  = valid_i & regwe_i & ~(is_mem & misal);
                    mis_d    = valid_i & is_mem & misal;
                    cregwa_d = cregwa_i;
                    cregwd_d = cregwd_i;
                    rt_d     = rt_i;
                    rd_d     = rd_i;
                    aluout_d = aluout_i;
                    memrd_d  = 32'h0;
                end
            end
            BUSY: begin
                if (dm_ack_i) begin
                    // Upstream still holds the entry, so it is loaded from inputs
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    be_d     = 4'b0000;
                    valid_d  = valid_i;
                    regwe_d  = valid_i & regwe_i;
                    cregwa_d = cregwa_i;
                    cregwd_d = cregwd_i;
                    rt_d     = rt_i;
                    rd_d     = rd_i;
                    aluout_d = aluout_i;
                    memrd_d  = we_q ? 32'h0 : ld_data;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            sz_q     <= 2'b00;
            sx_q     <= 1'b0;
            lane_q   <= 2'b00;
            valid_q  <= 1'b0;
            cregwa_q <= 1'b0;
            cregwd_q <= 2'b00;
            regwe_q  <= 1'b0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            aluout_q <= 32'h0;
            memrd_q  <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sz_q     <= sz_d;
            sx_q     <= sx_d;
            lane_q   <= lane_d;
            valid_q  <= valid_d;
            cregwa_q <= cregwa_d;
            cregwd_q <= cregwd_d;
            regwe_q  <= regwe_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            aluout_q <= aluout_d;
            memrd_q  <= memrd_d;
            mis_q    <= mis_d;
        end
    end

    assign dm_req_o   = req_q;
    assign dm_we_o    = we_q;
    assign dm_be_o    = be_q;
    assign dm_addr_o  = addr_q;
    assign dm_wdata_o = wdata_q;
    assign valid_o    = valid_q;
    assign cregwa_o   = cregwa_q;
    assign cregwd_o   = cregwd_q;
    assign regwe_o    = regwe_q;
    assign rt_o       = rt_q;
    assign rd_o       = rd_q;
    assign aluout_o   = aluout_q;
    assign memrd_o    = memrd_q;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors for the memory stage.
// Acks are driven by hand after a chosen number of request cycles.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, cregwa_i, regwe_i;
    logic [1:0]  cregwd_i, memsz_i;
    logic [4:0]  rt_i, rd_i;
    logic [31:0] aluout_i, wdata_i, dm_rdata_i;
    logic        memre_i, memwe_i, memsx_i, dm_ack_i;
    logic        stall_o, dm_req_o, dm_we_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        valid_o, cregwa_o, regwe_o, misalign_o;
    logic [1:0]  cregwd_o;
    logic [4:0]  rt_o, rd_o;
    logic [31:0] aluout_o, memrd_o;

    int n_chk = 0;
    int n_pass = 0;

    int          nst, nrq, nbb;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;
    logic        c_we, held, done;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .cregwa_i(cregwa_i), .cregwd_i(cregwd_i),
        .regwe_i(regwe_i), .rt_i(rt_i), .rd_i(rd_i), .aluout_i(aluout_i),
        .memre_i(memre_i), .memwe_i(memwe_i), .memsz_i(memsz_i),
        .memsx_i(memsx_i), .wdata_i(wdata_i), .stall_o(stall_o),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_be_o(dm_be_o),
        .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
        .valid_o(valid_o), .cregwa_o(cregwa_o), .cregwd_o(cregwd_o),
        .regwe_o(regwe_o), .rt_o(rt_o), .rd_o(rd_o), .aluout_o(aluout_o),
        .memrd_o(memrd_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        valid_i  = 1'b0;
        regwe_i  = 1'b0;
        memre_i  = 1'b0;
        memwe_i  = 1'b0;
        memsz_i  = 2'b00;
        memsx_i  = 1'b0;
        cregwa_i = 1'b0;
        cregwd_i = 2'b00;
        rt_i     = 5'd0;
        rd_i     = 5'd0;
        aluout_i = 32'h0;
        wdata_i  = 32'h0;
    endtask

    task automatic set_op(input logic re, input logic we, input logic rwe,
                          input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd);
        valid_i  = 1'b1;
        regwe_i  = rwe;
        memre_i  = re;
        memwe_i  = we;
        memsz_i  = sz;
        memsx_i  = sx;
        aluout_i = a;
        wdata_i  = wd;
        rd_i     = rd;
        rt_i     = rd + 5'd1;
        cregwa_i = 1'b1;
        cregwd_i = re ? 2'b01 : 2'b00;
    endtask

    // Runs one accepted memory op; ack comes in the dly-th request cycle.
    task automatic mem_txn(input int dly);
        nst = 0; nrq = 0; nbb = 0;
        held = 1'b1; done = 1'b0;
        c_addr = 32'h0; c_wd = 32'h0; c_be = 4'h0; c_we = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (dm_req_o) begin
                if (nrq == 0) begin
                    c_addr = dm_addr_o; c_wd = dm_wdata_o;
                    c_be = dm_be_o; c_we = dm_we_o;
                end else if (dm_addr_o !== c_addr || dm_wdata_o !== c_wd ||
                             dm_be_o !== c_be || dm_we_o !== c_we) begin
                    held = 1'b0;
                end
                nrq++;
            end
            dm_ack_i = dm_req_o && (nrq == dly);
            #1;
            if (stall_o) nst++;
            @(posedge clk);
            #1;
            if (dm_ack_i) begin
                dm_ack_i = 1'b0;
                done = 1'b1;
            end else if (!valid_o) begin
                nbb++;
            end
        end
        chk("txn_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        dm_ack_i = 1'b0;
        dm_rdata_i = 32'h0;
        idle_in();
        step();
        step();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_regwe", {31'd0, regwe_o}, 32'd0);
        chk("rst_req", {31'd0, dm_req_o}, 32'd0);
        chk("rst_we", {31'd0, dm_we_o}, 32'd0);
        chk("rst_be", {28'd0, dm_be_o}, 32'd0);
        chk("rst_addr", dm_addr_o, 32'd0);
        chk("rst_memrd", memrd_o, 32'd0);
        chk("rst_mis", {31'd0, misalign_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // plain ALU op
        idle_in();
        valid_i = 1'b1; regwe_i = 1'b1; aluout_i = 32'h1234;
        rd_i = 5'd5; cregwd_i = 2'b10;
        #1;
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("alu_valid", {31'd0, valid_o}, 32'd1);
        chk("alu_regwe", {31'd0, regwe_o}, 32'd1);
        chk("alu_out", aluout_o, 32'h1234);
        chk("alu_rd", {27'd0, rd_o}, 32'd5);
        chk("alu_cregwd", {30'd0, cregwd_o}, 32'd2);
        chk("alu_req", {31'd0, dm_req_o}, 32'd0);
        idle_in();
        step();
        chk("alu_drop", {31'd0, valid_o}, 32'd0);

        // lb sign-extended from lane 3, ack one cycle after request
        set_op(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7);
        dm_rdata_i = 32'h80AABBCC;
        mem_txn(2);
        chk("lb_addr", c_addr, 32'h100);
        chk("lb_be", {28'd0, c_be}, 32'd0);
        chk("lb_we", {31'd0, c_we}, 32'd0);
        chk("lb_nstall", nst, 32'd2);
        chk("lb_nreq", nrq, 32'd2);
        chk("lb_valid", {31'd0, valid_o}, 32'd1);
        chk("lb_regwe", {31'd0, regwe_o}, 32'd1);
        chk("lb_memrd", memrd_o, 32'hFFFFFF80);
        chk("lb_rd", {27'd0, rd_o}, 32'd7);
        idle_in();
        step();

        // sh in upper half, ack after three request cycles
        set_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 5'd0);
        mem_txn(3);
        chk("sh_nreq", nrq, 32'd3);
        chk("sh_nbub", nbb, 32'd3);
        chk("sh_be", {28'd0, c_be}, 32'hC);
        chk("sh_wdata", c_wd, 32'hBEEFBEEF);
        chk("sh_we", {31'd0, c_we}, 32'd1);
        chk("sh_held", {31'd0, held}, 32'd1);
        chk("sh_valid", {31'd0, valid_o}, 32'd1);
        chk("sh_regwe", {31'd0, regwe_o}, 32'd0);
        chk("sh_memrd", memrd_o, 32'd0);
        idle_in();
        step();

        // sb lane 1, lhu lane 2
        set_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0000005A, 5'd0);
        mem_txn(1);
        chk("sb_be", {28'd0, c_be}, 32'h2);
        chk("sb_wdata", c_wd, 32'h5A5A5A5A);
        chk("sb_addr", c_addr, 32'h100);
        idle_in();
        step();
        set_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0, 5'd9);
        dm_rdata_i = 32'h80AABBCC;
        mem_txn(1);
        chk("lhu_nstall", nst, 32'd1);
        chk("lhu_memrd", memrd_o, 32'h000080AA);
        idle_in();
        step();

        // misaligned lw
        set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'h0, 5'd3);
        #1;
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("mis_req", {31'd0, dm_req_o}, 32'd0);
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        chk("mis_valid", {31'd0, valid_o}, 32'd1);
        chk("mis_regwe", {31'd0, regwe_o}, 32'd0);
        idle_in();
        step();
        chk("mis_pulse", {31'd0, misalign_o}, 32'd0);

        // reset in the second BUSY cycle, late ack ignored
        set_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h11223344, 5'd0);
        step();
        step();
        chk("rb_req", {31'd0, dm_req_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_req_drop", {31'd0, dm_req_o}, 32'd0);
        chk("rb_we", {31'd0, dm_we_o}, 32'd0);
        chk("rb_be", {28'd0, dm_be_o}, 32'd0);
        chk("rb_addr", dm_addr_o, 32'd0);
        idle_in();
        @(negedge clk);
        rst = 1'b0;
        dm_ack_i = 1'b1;
        step();
        dm_ack_i = 1'b0;
        chk("rb_ack_req", {31'd0, dm_req_o}, 32'd0);
        chk("rb_ack_valid", {31'd0, valid_o}, 32'd0);
        chk("rb_stall", {31'd0, stall_o}, 32'd0);

        // back-to-back lw 0x0 / lw 0x4
        set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 5'd10);
        dm_rdata_i = 32'hDEADBEEF;
        mem_txn(1);
        chk("b2b1_valid", {31'd0, valid_o}, 32'd1);
        chk("b2b1_memrd", memrd_o, 32'hDEADBEEF);
        chk("b2b1_rd", {27'd0, rd_o}, 32'd10);
        set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 5'd11);
        dm_rdata_i = 32'h01234567;
        chk("b2b_gap", {31'd0, dm_req_o}, 32'd0);
        mem_txn(1);
        chk("b2b2_addr", c_addr, 32'h4);
        chk("b2b2_nbub", nbb, 32'd1);
        chk("b2b2_valid", {31'd0, valid_o}, 32'd1);
        chk("b2b2_memrd", memrd_o, 32'h01234567);
        chk("b2b2_rd", {27'd0, rd_o}, 32'd11);
        idle_in();
        step();
        chk("b2b_end", {31'd0, valid_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
